// File: rtl/dmem_lsu_pkg.sv
// rtl/dmem_lsu_pkg.sv - shared encodings and helper functions for the load/store unit
package dmem_lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_X = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        ERR  = 3'd3,
        RESP = 3'd4
    } state_e;

    // A request is rejected when its size is illegal or the address is not
    // a multiple of the access size.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = addr_lo[0];
            SZ_W:    bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Byte lanes touched by an access of the given size at the given offset.
    function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            SZ_B:    be = 4'b0001 << addr_lo;
            SZ_H:    be = 4'b0011 << {addr_lo[1], 1'b0};
            SZ_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// rtl/dmem_lsu_if.sv - core-side and RAM-side signal bundle for the load/store unit
interface dmem_lsu_if #(
    parameter int ADDR_W = 15
) ();

    // core memory stage <-> LSU
    logic              cpu_req;
    logic              cpu_we;
    logic [1:0]        cpu_size;
    logic              cpu_unsigned;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic              cpu_ready;
    logic              cpu_rvalid;
    logic [31:0]       cpu_rdata;
    logic              cpu_err;

    // LSU <-> cpu_ram data port
    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic              d_we;
    logic [3:0]        d_be;
    logic [31:0]       d_wdata;
    logic [31:0]       d_rdata;
    logic              d_valid;

    modport cpu_master (
        output cpu_req, cpu_we, cpu_size, cpu_unsigned, cpu_addr, cpu_wdata,
        input  cpu_ready, cpu_rvalid, cpu_rdata, cpu_err
    );

    modport cpu_slave (
        input  cpu_req, cpu_we, cpu_size, cpu_unsigned, cpu_addr, cpu_wdata,
        output cpu_ready, cpu_rvalid, cpu_rdata, cpu_err
    );

    modport d_master (
        output d_req, d_addr, d_we, d_be, d_wdata,
        input  d_rdata, d_valid
    );

    modport d_slave (
        input  d_req, d_addr, d_we, d_be, d_wdata,
        output d_rdata, d_valid
    );

endinterface

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - store lane replication and load lane extract/extend
module lsu_lane_align
    import dmem_lsu_pkg::*;
(
    input  logic [1:0]  st_size_i,
    input  logic [31:0] st_wdata_i,
    output logic [31:0] st_wdata_o,
    input  logic [1:0]  ld_size_i,
    input  logic [1:0]  ld_addr_lo_i,
    input  logic        ld_unsigned_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Replicate narrow store data on every lane so the byte enables alone pick the target.
    always_comb begin
        st_wdata_o = st_wdata_i;
        case (st_size_i)
            SZ_B:    st_wdata_o = {4{st_wdata_i[7:0]}};
            SZ_H:    st_wdata_o = {2{st_wdata_i[15:0]}};
            default: st_wdata_o = st_wdata_i;
        endcase
    end

    // Pick the addressed lane out of the RAM word and extend it to 32 bits.
    always_comb begin
        byte_v    = ld_rdata_i[7:0];
        half_v    = ld_addr_lo_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
        ld_data_o = ld_rdata_i;
        case (ld_addr_lo_i)
            2'd0:    byte_v = ld_rdata_i[7:0];
            2'd1:    byte_v = ld_rdata_i[15:8];
            2'd2:    byte_v = ld_rdata_i[23:16];
            default: byte_v = ld_rdata_i[31:24];
        endcase
        case (ld_size_i)
            SZ_B:    ld_data_o = ld_unsigned_i ? {24'd0, byte_v} : {{24{byte_v[7]}}, byte_v};
            SZ_H:    ld_data_o = ld_unsigned_i ? {16'd0, half_v} : {{16{half_v[15]}}, half_v};
            default: ld_data_o = ld_rdata_i;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - load/store unit between core memory stage and cpu_ram D port
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int ADDR_W  = 15,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          reset,
    dmem_lsu_if.cpu_slave cpu,
    dmem_lsu_if.d_master  ram
);

    localparam int                CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [1:0]         size_q, size_d;
    logic               uns_q, uns_d;
    logic [1:0]         addr_lo_q, addr_lo_d;
    logic               err_q, err_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [ADDR_W-1:0]  daddr_q, daddr_d;
    logic [3:0]         dbe_q, dbe_d;
    logic [31:0]        dwdata_q, dwdata_d;

    logic [31:0]        st_rep;
    logic [31:0]        ld_ext;

    lsu_lane_align u_lane (
        .st_size_i     (cpu.cpu_size),
        .st_wdata_i    (cpu.cpu_wdata),
        .st_wdata_o    (st_rep),
        .ld_size_i     (size_q),
        .ld_addr_lo_i  (addr_lo_q),
        .ld_unsigned_i (uns_q),
        .ld_rdata_i    (ram.d_rdata),
        .ld_data_o     (ld_ext)
    );

    // Next-state, capture, RAM-request and completion logic for one outstanding access.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        size_d    = size_q;
        uns_d     = uns_q;
        addr_lo_d = addr_lo_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        daddr_d   = daddr_q;
        dbe_d     = dbe_q;
        dwdata_d  = dwdata_q;

        case (state_q)
            IDLE: begin
                err_d   = 1'b0;
                rdata_d = '0;
                if (cpu.cpu_req) begin
                    we_d      = cpu.cpu_we;
                    size_d    = cpu.cpu_size;
                    uns_d     = cpu.cpu_unsigned;
                    addr_lo_d = cpu.cpu_addr[1:0];
                    if (misaligned(cpu.cpu_size, cpu.cpu_addr[1:0])) begin
                        state_d = ERR;
                    end else begin
                        state_d  = REQ;
                        daddr_d  = {cpu.cpu_addr[ADDR_W-1:2], 2'b00};
                        dbe_d    = cpu.cpu_we ? be_gen(cpu.cpu_size, cpu.cpu_addr[1:0]) : 4'b0000;
                        dwdata_d = cpu.cpu_we ? st_rep : 32'd0;
                    end
                end
            end
            REQ: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (ram.d_valid) begin
                    state_d  = RESP;
                    err_d    = 1'b0;
                    rdata_d  = we_q ? 32'd0 : ld_ext;
                    daddr_d  = '0;
                    dbe_d    = 4'b0000;
                    dwdata_d = 32'd0;
                end else if (cnt_q == CNT_LAST) begin
                    // RAM never answered; a response arriving after this is stale.
                    state_d  = RESP;
                    err_d    = 1'b1;
                    rdata_d  = 32'd0;
                    daddr_d  = '0;
                    dbe_d    = 4'b0000;
                    dwdata_d = 32'd0;
                end else begin
                    cnt_d = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + 1'b1;
                end
            end
            ERR: begin
                state_d = RESP;
                err_d   = 1'b1;
                rdata_d = 32'd0;
            end
            RESP: begin
                state_d = IDLE;
                err_d   = 1'b0;
                rdata_d = 32'd0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, capture and RAM-request registers; reset aborts any access in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            size_q    <= 2'b00;
            uns_q     <= 1'b0;
            addr_lo_q <= 2'b00;
            err_q     <= 1'b0;
            rdata_q   <= 32'd0;
            daddr_q   <= '0;
            dbe_q     <= 4'b0000;
            dwdata_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            size_q    <= size_d;
            uns_q     <= uns_d;
            addr_lo_q <= addr_lo_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            daddr_q   <= daddr_d;
            dbe_q     <= dbe_d;
            dwdata_q  <= dwdata_d;
        end
    end

    // Outputs decoded from the state register so nothing leaks outside RESP or REQ.
    always_comb begin
        cpu.cpu_ready  = (state_q == IDLE);
        cpu.cpu_rvalid = (state_q == RESP);
        cpu.cpu_err    = (state_q == RESP) && err_q;
        cpu.cpu_rdata  = (state_q == RESP) ? rdata_q : 32'd0;
        ram.d_req      = (state_q == REQ);
        ram.d_addr     = daddr_q;
        ram.d_be       = dbe_q;
        ram.d_we       = |dbe_q;
        ram.d_wdata    = dwdata_q;
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - self-checking bench for dmem_lsu
module tb_dmem_lsu;

    localparam int AW = 15;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dmem_lsu_if #(.ADDR_W(AW)) bus ();

    dmem_lsu #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .cpu   (bus),
        .ram   (bus)
    );

    int checks = 0;
    int errors = 0;

    // RAM model (word array with byte enables) and reference memory (plain bytes)
    logic [31:0]  ram_mem [0:8191];
    byte unsigned ref_mem [0:32767];

    int          dreq_count = 0;
    int          rv_count   = 0;
    int          countdown  = 0;
    int          ram_lat    = 1;
    bit          withhold   = 1'b0;
    bit          late_fire  = 1'b0;
    logic [12:0] pend_idx;
    logic [AW-1:0] last_addr;
    logic [3:0]  last_be;
    logic        last_we;
    logic [31:0] last_wdata;

    typedef struct {
        bit          we;
        logic [1:0]  size;
        bit          uns;
        logic [14:0] addr;
        logic [31:0] wdata;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          exp_lat;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // cpu_ram stand-in: answers each d_req after ram_lat cycles unless withheld
    initial begin
        bus.d_valid = 1'b0;
        bus.d_rdata = 32'd0;
        forever begin
            @(negedge clk);
            bus.d_valid = 1'b0;
            bus.d_rdata = 32'd0;
            if (countdown > 0) begin
                countdown--;
                if (countdown == 0) begin
                    bus.d_valid = 1'b1;
                    bus.d_rdata = ram_mem[pend_idx];
                end
            end
            if (late_fire) begin
                bus.d_valid = 1'b1;
                bus.d_rdata = 32'hBAD0_BAD0;
                late_fire   = 1'b0;
            end
            if (bus.d_req === 1'b1) begin
                dreq_count++;
                last_addr  = bus.d_addr;
                last_be    = bus.d_be;
                last_we    = bus.d_we;
                last_wdata = bus.d_wdata;
                pend_idx   = bus.d_addr[14:2];
                for (int i = 0; i < 4; i++)
                    if (bus.d_be[i]) ram_mem[pend_idx][8*i +: 8] = bus.d_wdata[8*i +: 8];
                if (!withhold) countdown = ram_lat;
            end
            if (bus.cpu_rvalid === 1'b1) rv_count++;
        end
    end

    function automatic bit ref_bad(input int size, input int addr);
        return (size == 3) || (size == 1 && (addr % 2) != 0) || (size == 2 && (addr % 4) != 0);
    endfunction

    function automatic logic [31:0] ref_load(input int size, input bit uns, input int addr);
        int n;
        logic [31:0] v;
        n = 1 << size;
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[addr + i]) << (8 * i));
        if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    task automatic ref_store(input int size, input int addr, input logic [31:0] w);
        for (int i = 0; i < (1 << size); i++) ref_mem[addr + i] = 8'(w >> (8 * i));
    endtask

    function automatic logic [3:0] ref_be(input int size, input int addr);
        return 4'(((1 << (1 << size)) - 1) << (addr % 4));
    endfunction

    function automatic logic [31:0] ref_wdata(input int size, input logic [31:0] w);
        if (size == 0) return (w & 32'hFF) * 32'h0101_0101;
        if (size == 1) return (w & 32'hFFFF) * 32'h0001_0001;
        return w;
    endfunction

    // One complete access: returns result, error, cycles from accept to rvalid, d_req count
    task automatic do_op(input bit we, input logic [1:0] size, input bit uns,
                         input logic [14:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output bit err,
                         output int lat, output int ndreq);
        int w;
        int cyc;
        int n0;
        bit got;
        w = 0;
        @(negedge clk);
        while (bus.cpu_ready !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (bus.cpu_ready !== 1'b1) chk("ready_before_op", bus.cpu_ready, 1);
        bus.cpu_req      = 1'b1;
        bus.cpu_we       = we;
        bus.cpu_size     = size;
        bus.cpu_unsigned = uns;
        bus.cpu_addr     = addr;
        bus.cpu_wdata    = wdata;
        n0 = dreq_count;
        @(posedge clk);
        #1;
        bus.cpu_req = 1'b0;
        cyc   = 0;
        got   = 1'b0;
        rdata = 32'hX;
        err   = 1'b1;
        while (!got && cyc < TO + 20) begin
            @(negedge clk);
            cyc++;
            if (bus.cpu_rvalid === 1'b1) begin
                got   = 1'b1;
                rdata = bus.cpu_rdata;
                err   = bus.cpu_err;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL rvalid_wait actual=none required=pulse within %0d cycles", TO + 20);
        end
        lat   = cyc;
        ndreq = dreq_count - n0;
        @(negedge clk);
        chk("rvalid_single_pulse", bus.cpu_rvalid, 0);
        chk("ready_after_resp", bus.cpu_ready, 1);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ready"},  bus.cpu_ready, 1);
        chk({tag, "_rvalid"}, bus.cpu_rvalid, 0);
        chk({tag, "_rdata"},  bus.cpu_rdata, 0);
        chk({tag, "_err"},    bus.cpu_err, 0);
        chk({tag, "_dreq"},   bus.d_req, 0);
        chk({tag, "_daddr"},  32'(bus.d_addr), 0);
        chk({tag, "_dbe"},    bus.d_be, 0);
        chk({tag, "_dwe"},    bus.d_we, 0);
        chk({tag, "_dwdata"}, bus.d_wdata, 0);
    endtask

    initial begin : main
        logic [31:0] rd;
        bit er;
        int lat;
        int nd;
        int r0;
        int n0;
        logic [31:0] exp_rd;

        for (int i = 0; i < 8192; i++) ram_mem[i] = 32'd0;
        for (int i = 0; i < 32768; i++) ref_mem[i] = 8'd0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_size = 2'b00;
        bus.cpu_unsigned = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = 32'd0;

        tbl[0]  = '{1'b1, 2'd2, 1'b0, 15'h0010, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 3};
        tbl[1]  = '{1'b0, 2'd2, 1'b0, 15'h0010, 32'h0,         4'b0000, 32'h0,         32'hDEAD_BEEF, 1'b0, 3};
        tbl[2]  = '{1'b1, 2'd0, 1'b0, 15'h0013, 32'h1234_5680, 4'b1000, 32'h8080_8080, 32'h0000_0000, 1'b0, 3};
        tbl[3]  = '{1'b0, 2'd0, 1'b0, 15'h0013, 32'h0,         4'b0000, 32'h0,         32'hFFFF_FF80, 1'b0, 3};
        tbl[4]  = '{1'b0, 2'd0, 1'b1, 15'h0013, 32'h0,         4'b0000, 32'h0,         32'h0000_0080, 1'b0, 3};
        tbl[5]  = '{1'b1, 2'd1, 1'b0, 15'h0022, 32'hABCD_8001, 4'b1100, 32'h8001_8001, 32'h0000_0000, 1'b0, 3};
        tbl[6]  = '{1'b0, 2'd1, 1'b0, 15'h0022, 32'h0,         4'b0000, 32'h0,         32'hFFFF_8001, 1'b0, 3};
        tbl[7]  = '{1'b0, 2'd1, 1'b0, 15'h0021, 32'h0,         4'b0000, 32'h0,         32'h0000_0000, 1'b1, 2};
        tbl[8]  = '{1'b0, 2'd2, 1'b0, 15'h0006, 32'h0,         4'b0000, 32'h0,         32'h0000_0000, 1'b1, 2};
        tbl[9]  = '{1'b0, 2'd3, 1'b0, 15'h0010, 32'h0,         4'b0000, 32'h0,         32'h0000_0000, 1'b1, 2};
        tbl[10] = '{1'b0, 2'd2, 1'b0, 15'h0020, 32'h0,         4'b0000, 32'h0,         32'h8001_0000, 1'b0, 3};
        tbl[11] = '{1'b0, 2'd1, 1'b1, 15'h0012, 32'h0,         4'b0000, 32'h0,         32'h0000_80AD, 1'b0, 3};
        tbl[12] = '{1'b0, 2'd0, 1'b0, 15'h0011, 32'h0,         4'b0000, 32'h0,         32'hFFFF_FFBE, 1'b0, 3};

        // reset state, checked while reset is held
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // directed table
        for (int i = 0; i < 13; i++) begin
            ram_lat = 1;
            do_op(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata, rd, er, lat, nd);
            chk($sformatf("row%0d_err", i), er, tbl[i].exp_err);
            chk($sformatf("row%0d_rdata", i), rd, tbl[i].exp_rdata);
            chk($sformatf("row%0d_latency", i), lat, tbl[i].exp_lat);
            chk($sformatf("row%0d_dreq_count", i), nd, tbl[i].exp_err ? 0 : 1);
            if (!tbl[i].exp_err) begin
                chk($sformatf("row%0d_daddr", i), 32'(last_addr), 32'(tbl[i].addr & 15'h7FFC));
                chk($sformatf("row%0d_dbe", i), last_be, tbl[i].exp_be);
                chk($sformatf("row%0d_dwe", i), last_we, |tbl[i].exp_be);
                if (tbl[i].we) chk($sformatf("row%0d_dwdata", i), last_wdata, tbl[i].exp_wdata);
                if (tbl[i].we) ref_store(tbl[i].size, tbl[i].addr, tbl[i].wdata);
            end
        end

        // timeout: RAM withholds d_valid, then a late d_valid must be ignored
        withhold = 1'b1;
        do_op(1'b0, 2'd2, 1'b0, 15'h0010, 32'h0, rd, er, lat, nd);
        chk("timeout_err", er, 1);
        chk("timeout_rdata", rd, 0);
        chk("timeout_latency", lat, TO + 2);
        chk("timeout_dreq_count", nd, 1);
        r0 = rv_count;
        @(posedge clk);
        late_fire = 1'b1;
        repeat (4) @(negedge clk);
        chk("late_valid_no_rvalid", rv_count - r0, 0);
        chk("late_valid_ready", bus.cpu_ready, 1);
        withhold = 1'b0;
        ram_lat  = 1;
        do_op(1'b0, 2'd2, 1'b0, 15'h0010, 32'h0, rd, er, lat, nd);
        chk("after_timeout_err", er, 0);
        chk("after_timeout_rdata", rd, ref_load(2, 1'b0, 16));
        chk("after_timeout_latency", lat, 3);

        // reset during WAIT, RAM answers after release
        withhold = 1'b1;
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_size = 2'd2;
        bus.cpu_unsigned = 1'b0; bus.cpu_addr = 15'h0020;
        n0 = dreq_count;
        @(posedge clk);
        #1;
        bus.cpu_req = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_wait_dreq_seen", dreq_count - n0, 1);
        chk("rst_wait_busy", bus.cpu_ready, 0);
        r0 = rv_count;
        reset = 1'b0;
        #1;
        chk_idle_outputs("rst_mid");
        @(negedge clk);
        reset    = 1'b1;
        withhold = 1'b0;
        @(posedge clk);
        late_fire = 1'b1;
        repeat (6) @(negedge clk);
        chk("rst_no_rvalid", rv_count - r0, 0);
        chk_idle_outputs("rst_after");
        do_op(1'b0, 2'd2, 1'b0, 15'h0020, 32'h0, rd, er, lat, nd);
        chk("rst_next_err", er, 0);
        chk("rst_next_rdata", rd, ref_load(2, 1'b0, 32));

        // randomized accesses against the byte-level reference memory
        for (int k = 0; k < 150; k++) begin
            int r;
            int sz;
            int ad;
            bit we;
            bit un;
            logic [31:0] wd;
            bit bad;
            r  = $urandom_range(0, 9);
            sz = (r < 3) ? 0 : (r < 6) ? 1 : (r < 9) ? 2 : 3;
            ad = 256 + $urandom_range(0, 63);
            we = $urandom_range(0, 1);
            un = $urandom_range(0, 1);
            wd = $urandom;
            ram_lat = $urandom_range(1, 5);
            bad = ref_bad(sz, ad);
            exp_rd = (bad || we) ? 32'd0 : ref_load(sz, un, ad);
            do_op(we, 2'(sz), un, 15'(ad), wd, rd, er, lat, nd);
            chk($sformatf("rnd%0d_err", k), er, bad);
            chk($sformatf("rnd%0d_rdata", k), rd, exp_rd);
            chk($sformatf("rnd%0d_latency", k), lat, bad ? 2 : 2 + ram_lat);
            chk($sformatf("rnd%0d_dreq_count", k), nd, bad ? 0 : 1);
            if (!bad) begin
                chk($sformatf("rnd%0d_daddr", k), 32'(last_addr), 32'(ad - (ad % 4)));
                chk($sformatf("rnd%0d_dbe", k), last_be, we ? ref_be(sz, ad) : 4'b0000);
                if (we) begin
                    chk($sformatf("rnd%0d_dwdata", k), last_wdata, ref_wdata(sz, wd));
                    ref_store(sz, ad, wd);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store unit between the CPU core's memory stage and the data port (D port) of cpu_ram.
- Accepts byte, halfword and word requests at any byte address and checks alignment.
- Drives the word-aligned D-port request with shifted write data and byte enables.
- Waits for d_valid, then returns read data extracted and sign/zero-extended, with an error flag for misalignment or RAM timeout.
- One transaction outstanding at a time.

Parameters:
ADDR_W, 15, byte-address width (matches cpu_ram size 13 + 2)
TIMEOUT, 64, cycles to wait for d_valid after d_req before flagging error (>=2)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
cpu_req  in  1  request strobe, sampled only when cpu_ready=1
cpu_we  in  1  1=store, 0=load
cpu_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
cpu_unsigned  in  1  loads: 1=zero-extend, 0=sign-extend
cpu_addr  in  ADDR_W  byte address
cpu_wdata  in  32  store data, right-aligned
cpu_ready  out  1  block idle, can accept
cpu_rvalid  out  1  one-cycle completion pulse (loads and stores)
cpu_rdata  out  32  load result, valid with cpu_rvalid, 0 otherwise
cpu_err  out  1  with cpu_rvalid: misaligned/illegal or timeout
d_req  out  1  one-cycle request to cpu_ram
d_addr  out  ADDR_W  word-aligned address, bits [1:0] always 0
d_we  out  1  equals |d_be
d_be  out  4  byte enables, 0000 for loads
d_wdata  out  32  lane-replicated store data
d_rdata  in  32  RAM read data, valid with d_valid
d_valid  in  1  RAM completion

Behaviour:
- Reset (reset=0, async): state IDLE, cpu_ready=1, all other outputs 0, timeout counter 0, captured request cleared.
- States:
  - IDLE: cpu_ready=1. On cpu_req, capture all cpu_* inputs. Misaligned -> ERR, aligned -> REQ.
  - Misaligned means: half with addr[0]=1; word with addr[1:0]!=0; size 11.
  - REQ: d_req=1 for exactly this cycle. Counter loads 0. Go to WAIT.
  - WAIT: counter increments each cycle. On d_valid, register the load result and go to RESP. If counter reaches TIMEOUT-1 without d_valid, go to RESP with the error flag set.
  - ERR: go to RESP with the error flag set. d_req is never asserted.
  - RESP: cpu_rvalid=1 for one cycle. cpu_err as flagged. cpu_rdata is the load result, or 0 for stores and errors. Go to IDLE.
- d_addr, d_be, d_we, d_wdata are registered and held stable from REQ through WAIT. They return to 0 in IDLE.
- Minimum latency: accept at T0, d_req at T1, d_valid at T2 earliest (sampled in WAIT), cpu_rvalid at T3, cpu_ready at T4.
- d_valid during REQ is impossible by cpu_ram timing and is ignored. d_valid in IDLE, ERR or RESP is ignored (late or stale). cpu_req while cpu_ready=0 is ignored.
- Store byte enables and data:
  - Byte: d_be = 0001 << addr[1:0]; d_wdata = {4{wdata[7:0]}}.
  - Half: d_be = 0011 << {addr[1],1'b0}; d_wdata = {2{wdata[15:0]}}.
  - Word: d_be = 1111; d_wdata = wdata.
- Loads: lane selected by captured addr[1:0] (half uses addr[1]), then extended to 32 bits per cpu_unsigned.
- Timeout: the counter saturates and never wraps. A d_valid arriving after the timeout fired is ignored.
- Reset asserted mid-transaction aborts immediately: no cpu_rvalid is produced, and the pending d_valid is ignored after reset release.

Decomposition:
- Package dmem_lsu_pkg:
  - size encodings (SZ_B, SZ_H, SZ_W);
  - state encoding (IDLE, REQ, WAIT, ERR, RESP);
  - functions be_gen(size, addr[1:0]) and misaligned(size, addr[1:0]).
- Sub-module lsu_lane_align: combinational store replication plus load extract/extend, instantiated once.
- The FSM, capture registers and timeout counter stay in dmem_lsu.

Test Plan:
- Word store 0xDEADBEEF at 0x0010, then word load at 0x0010 -> d_be=1111, d_addr=0x0010, cpu_rdata=0xDEADBEEF, cpu_err=0, cpu_rvalid exactly 3 cycles after accept.
- Byte store 0x80 at 0x0013, then loads at 0x0013:
  - signed -> d_be=1000, d_wdata=0x80808080, cpu_rdata=0xFFFFFF80;
  - unsigned -> cpu_rdata=0x00000080.
- Half store 0x8001 at 0x0022, then signed half load at 0x0022 -> d_be=1100, cpu_rdata=0xFFFF8001. A half load at 0x0021 -> no d_req, cpu_rvalid with cpu_err=1, cpu_rdata=0.
- Word load at 0x0006 and a size=11 request -> each gives cpu_err=1, d_req never asserted, cpu_ready back after 3 cycles.
- RAM model withholds d_valid -> cpu_err=1 pulse TIMEOUT+1 cycles after d_req. A later d_valid is ignored and the next request completes normally.
- Assert reset during WAIT, then the RAM returns d_valid after release -> no cpu_rvalid, all outputs 0, cpu_ready=1, and the next load returns correct data.
